// File: rtl/cpu_sys_pkg.sv
// Shared encodings for the CPU bus arbiter: FSM state codes and read-return owner codes.
package cpu_sys_pkg;

  localparam logic [1:0] S_RST = 2'd0;
  localparam logic [1:0] S_CPU = 2'd1;
  localparam logic [1:0] S_DMA = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Shares one single-port RAM between the 6502 core and a DMA master, and sequences CPU reset.
// The CPU owns the bus by default; DMA steals cycles by dropping RDY.
module cpu_bus_arbiter
  import cpu_sys_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned DMA_MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              cpu_reset,
  output logic              cpu_rdy,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic [7:0]        cpu_di,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  input  logic              dma_we,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned RstW    = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned ConsecW = $clog2(DMA_MAX_CONSEC + 1);

  logic [1:0]         state_q, state_d;
  logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [ConsecW-1:0] consec_q, consec_d, consec_inc;
  logic [1:0]         owner_q, owner_d;
  logic [7:0]         cpu_di_hold_q, cpu_di_hold_d;
  logic [7:0]         dma_rdata_q, dma_rdata_d;

  assign consec_inc = consec_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    consec_d      = consec_q;
    owner_d       = OWN_NONE;
    cpu_di_hold_d = (owner_q == OWN_CPU) ? mem_rdata : cpu_di_hold_q;
    dma_rdata_d   = (owner_q == OWN_DMA) ? mem_rdata : dma_rdata_q;
    case (state_q)
      S_RST: begin
        if (rst_cnt_q == '0) state_d = S_CPU;
        else                 rst_cnt_d = rst_cnt_q - 1'b1;
      end
      S_CPU: begin
        owner_d = OWN_CPU;
        if (dma_req) begin
          state_d  = S_DMA;
          consec_d = '0;
        end
      end
      S_DMA: begin
        consec_d = consec_inc;
        if (dma_req && !dma_we) owner_d = OWN_DMA;
        // Leaving after the burst limit forces at least one CPU cycle.
        if (!(dma_req && (consec_inc < ConsecW'(DMA_MAX_CONSEC)))) state_d = S_CPU;
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_RST;
      rst_cnt_q     <= RstW'(RESET_CYCLES - 1);
      consec_q      <= '0;
      owner_q       <= OWN_NONE;
      cpu_di_hold_q <= 8'h00;
      dma_rdata_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      consec_q      <= consec_d;
      owner_q       <= owner_d;
      cpu_di_hold_q <= cpu_di_hold_d;
      dma_rdata_q   <= dma_rdata_d;
    end
  end

  always_comb begin
    cpu_reset = (state_q == S_RST);
    cpu_rdy   = (state_q == S_CPU);
    dma_ack   = (state_q == S_DMA) && dma_req;
    if (state_q == S_DMA) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_req && dma_we;
    end else begin
      mem_addr  = cpu_ab;
      mem_wdata = cpu_do;
      mem_we    = (state_q == S_CPU) && cpu_we;
    end
  end

  // A read in flight when reset arrives is dropped, so rvalid is masked by reset_n.
  assign dma_rvalid = (owner_q == OWN_DMA) && reset_n;
  assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;
  assign cpu_di     = (owner_q == OWN_CPU) ? mem_rdata : cpu_di_hold_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed and randomized bench for cpu_bus_arbiter against a cycle-ownership reference model
// and a shadow copy of RAM contents.
module tb_cpu_bus_arbiter;

  localparam int RstCycles = 16;
  localparam int MaxConsec = 4;

  logic        clk;
  logic        reset_n;
  logic        cpu_reset, cpu_rdy, cpu_we;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do, cpu_di;
  logic        dma_req, dma_we, dma_ack, dma_rvalid;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we;

  cpu_bus_arbiter #(
    .ADDR_W        (16),
    .RESET_CYCLES  (RstCycles),
    .DMA_MAX_CONSEC(MaxConsec)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_reset (cpu_reset),
    .cpu_rdy   (cpu_rdy),
    .cpu_ab    (cpu_ab),
    .cpu_do    (cpu_do),
    .cpu_we    (cpu_we),
    .cpu_di    (cpu_di),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_we    (dma_we),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .dma_rvalid(dma_rvalid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write, 1-cycle read latency.
  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who owns each cycle and which read data is due.
  bit         m_valid = 0;
  int         m_rst_left = RstCycles;
  bit         m_dma = 0;
  int         m_run = 0;
  bit         m_cpu_pend = 0, m_dma_pend = 0;
  logic [7:0] m_cpu_pdata = 0, m_dma_pdata = 0, m_cpu_hold = 0, m_dma_last = 0;

  bit         e_cpu_own, e_dma_own, e_ack, e_we, e_rvalid;
  logic [7:0] e_rdata, e_cpu_di;
  logic       obs_ack, obs_rdy, obs_we, obs_rvalid, obs_rst;
  logic [7:0] obs_cpu_di, obs_rdata;
  logic [15:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0] rd_cpu, rd_dma;
    rd_cpu = 8'h00;
    rd_dma = 8'h00;
    #1;
    e_cpu_own = (m_rst_left == 0) && !m_dma;
    e_dma_own = (m_rst_left == 0) && m_dma;
    e_ack     = e_dma_own && dma_req;
    e_we      = e_cpu_own ? cpu_we : (e_ack && dma_we);
    e_rvalid  = m_dma_pend && reset_n;
    e_rdata   = e_rvalid ? m_dma_pdata : m_dma_last;
    e_cpu_di  = m_cpu_pend ? m_cpu_pdata : m_cpu_hold;
    obs_ack = dma_ack; obs_rdy = cpu_rdy; obs_we = mem_we; obs_rvalid = dma_rvalid;
    obs_rst = cpu_reset; obs_cpu_di = cpu_di; obs_rdata = dma_rdata; obs_addr = mem_addr;
    if (m_valid) begin
      chk("cpu_reset", cpu_reset, m_rst_left > 0);
      chk("cpu_rdy", cpu_rdy, e_cpu_own);
      chk("dma_ack", dma_ack, e_ack);
      chk("mem_we", mem_we, e_we);
      chk("dma_rvalid", dma_rvalid, e_rvalid);
      chk("dma_rdata", dma_rdata, e_rdata);
      chk("cpu_di", cpu_di, e_cpu_di);
      if (e_cpu_own) chk("mem_addr_cpu", mem_addr, cpu_ab);
      if (e_ack) chk("mem_addr_dma", mem_addr, dma_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_cpu_own ? cpu_do : dma_wdata);
    end
    @(posedge clk);
    if (m_valid) begin
      if (e_cpu_own) begin
        rd_cpu = shadow[cpu_ab];
        if (cpu_we) shadow[cpu_ab] = cpu_do;
      end
      if (e_ack) begin
        rd_dma = shadow[dma_addr];
        if (dma_we) shadow[dma_addr] = dma_wdata;
      end
    end
    if (!reset_n) begin
      m_valid = 1; m_rst_left = RstCycles; m_dma = 0; m_run = 0;
      m_cpu_pend = 0; m_dma_pend = 0; m_cpu_hold = 8'h00; m_dma_last = 8'h00;
    end else if (m_valid) begin
      if (e_rvalid) m_dma_last = m_dma_pdata;
      if (m_cpu_pend) m_cpu_hold = m_cpu_pdata;
      m_cpu_pend = e_cpu_own; m_cpu_pdata = rd_cpu;
      m_dma_pend = e_ack && !dma_we; m_dma_pdata = rd_dma;
      if (m_rst_left > 0) m_rst_left--;
      else if (!m_dma) begin
        if (dma_req) begin m_dma = 1; m_run = 0; end
      end else begin
        m_run++;
        if (!(dma_req && m_run < MaxConsec)) m_dma = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n, nwe;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    reset_n = 0; cpu_ab = 16'h0200; cpu_do = 0; cpu_we = 0;
    dma_req = 0; dma_addr = 0; dma_wdata = 0; dma_we = 0;
    @(negedge clk);

    // Reset sequence: 3 clocks low, then 16 clocks of cpu_reset.
    step(); step(); step();
    reset_n = 1;
    n = 0;
    while (cpu_reset === 1'b1 && n < 40) begin step(); n++; end
    chk("t1_rst_len", n, RstCycles);
    chk("t1_rdy_after", cpu_rdy, 1);

    // CPU write then read back.
    cpu_ab = 16'h0200; cpu_do = 8'hA5; cpu_we = 1;
    step();
    chk("t2_we", obs_we, 1);
    cpu_we = 0;
    step(); step();
    chk("t2_rd", obs_cpu_di, 8'hA5);

    // Single DMA write.
    dma_req = 1; dma_addr = 16'h1234; dma_wdata = 8'h3C; dma_we = 1;
    step();
    chk("t3_noack_cpu", obs_ack, 0);
    step();
    chk("t3_ack", obs_ack, 1);
    chk("t3_stall", obs_rdy, 0);
    chk("t3_we", obs_we, 1);
    chk("t3_addr", obs_addr, 16'h1234);
    dma_req = 0;
    step(); step();
    chk("t3_rdy_back", obs_rdy, 1);

    // DMA read of the same location.
    dma_req = 1; dma_we = 0;
    step(); step();
    chk("t4_ack", obs_ack, 1);
    dma_req = 0;
    step();
    chk("t4_rvalid", obs_rvalid, 1);
    chk("t4_rdata", obs_rdata, 8'h3C);
    step();

    // Starvation bound: 4 DMA grants then one CPU cycle; CPU sees stable DI.
    dma_req = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n += int'(obs_ack);
      chk("t5_cpu_di", obs_cpu_di, 8'hA5);
    end
    chk("t5_acks", n, 16);
    dma_req = 0;
    step(); step();

    // Reset right after a DMA read ack drops the read and restarts the sequence.
    dma_req = 1; dma_we = 0;
    step(); step();
    chk("t6_ack", obs_ack, 1);
    reset_n = 0; dma_req = 0;
    step();
    chk("t6_no_rvalid", obs_rvalid, 0);
    step();
    reset_n = 1;
    n = 0; nwe = 0;
    while (cpu_reset === 1'b1 && n < 40) begin step(); n++; nwe += int'(obs_we); end
    chk("t6_rst_len", n, RstCycles);
    chk("t6_no_we", nwe, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cpu_ab = 16'h0300 + 16'($urandom_range(0, 7));
      cpu_we = ($urandom_range(0, 9) < 3);
      cpu_do = 8'($urandom);
      if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_req = 1;
        dma_addr = 16'h0300 + 16'($urandom_range(0, 7));
        dma_we = $urandom_range(0, 1) == 1;
        dma_wdata = 8'($urandom);
      end else if (dma_req && $urandom_range(0, 29) == 0) begin
        dma_req = 0;
      end
      reset_n = ($urandom_range(0, 399) != 0);
      step();
      if (e_ack) dma_req = 0;
    end
    reset_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
